// File: rtl/div_sequencer.sv
// ---------------------------------------------------------------------------
// div_sequencer
//   Iterative restoring unsigned divider with its controller. One quotient bit
//   is produced per clock. The control unit sees a start/busy/done handshake.
//   Quotient, remainder and a divide-by-zero flag go to the ALU result mux.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      request a division (sampled only when busy=0)
//   abort        in   1      synchronous cancel of an in-flight division
//   dividend     in   WIDTH  numerator, captured on accepted start
//   divisor      in   WIDTH  denominator, captured on accepted start
//   busy         out  1      high while a division is in progress
//   done         out  1      one-cycle pulse: results valid from this cycle on
//   quotient     out  WIDTH  floor(dividend/divisor)
//   remainder    out  WIDTH  dividend mod divisor
//   div_by_zero  out  1      divisor was 0 for the last completed operation
// ---------------------------------------------------------------------------
module div_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;          // partial remainder
    logic [WIDTH-1:0]   q_q, q_d;          // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]   d_q, d_d;          // captured divisor
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     a_sh_s;            // shifted remainder, one bit wider than A
    logic [WIDTH+1:0]   diff_s;            // extra bit carries the borrow/sign
    logic [WIDTH-1:0]   a_step_s;
    logic [WIDTH-1:0]   q_step_s;
    logic               accept_s;

    // One restoring shift/subtract step computed from the current datapath.
    always_comb begin
        a_sh_s = {a_q, q_q[WIDTH-1]};
        diff_s = {1'b0, a_sh_s} - {2'b00, d_q};
        if (diff_s[WIDTH+1]) begin
            // Negative: restore. a_sh < D here, so it fits in WIDTH bits.
            a_step_s = a_sh_s[WIDTH-1:0];
            q_step_s = {q_q[WIDTH-2:0], 1'b0};
        end else begin
            // Non-negative: a_sh < 2D, so the difference fits in WIDTH bits.
            a_step_s = diff_s[WIDTH-1:0];
            q_step_s = {q_q[WIDTH-2:0], 1'b1};
        end
    end

    // Next-state, datapath and registered-output logic for the sequencer.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        q_d      = q_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dbz_d    = dbz_q;
        // abort takes priority over a simultaneous start
        accept_s = start & ~abort;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_ITER;
                        busy_d  = 1'b1;
                        a_d     = '0;
                        q_d     = dividend;
                        d_d     = divisor;
                        cnt_d   = CNT_W'(WIDTH);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ITER: begin
                if (abort) begin
                    // Drop the partial result; published outputs stay untouched.
                    state_d = S_IDLE;
                end else begin
                    a_d   = a_step_s;
                    q_d   = q_step_s;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        quot_d  = q_step_s;
                        rem_d   = a_step_s;
                        dbz_d   = 1'b0;
                    end else begin
                        busy_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_sequencer.sv
// ---------------------------------------------------------------------------
// tb_div_sequencer
//   Scoreboard bench for div_sequencer (WIDTH=8). Each accepted division pushes
//   its expected quotient/remainder/flag and the cycle in which done must
//   appear; a monitor on the falling edge pops and compares on every done.
// ---------------------------------------------------------------------------
module tb_div_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         due;
    } exp_t;

    exp_t       sb[$];
    int         cyc;
    int         n_checks;
    int         n_errors;
    logic [7:0] last_q;
    logic [7:0] last_r;
    logic       last_z;

    div_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges so expected done cycles can be stated up front.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Scoreboard monitor: every done pops one expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient",    {24'd0, quotient},  {24'd0, e.q});
                chk("remainder",   {24'd0, remainder}, {24'd0, e.r});
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
                chk("done_cycle",  cyc, e.due);
                chk("busy_in_done", {31'd0, busy}, 32'd0);
                last_q = e.q;
                last_r = e.r;
                last_z = e.z;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start cycle; optionally register the expected outcome.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit expect_done);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (expect_done) begin
            if (b == 8'd0) begin
                e.q = 8'hFF; e.r = a; e.z = 1'b1; e.due = cyc + 1;
            end else begin
                e.q = a / b; e.r = a % b; e.z = 1'b0; e.due = cyc + 9;
            end
            sb.push_back(e);
        end
        tick();
        start    = 1'b0;
        // Scramble operands so a late capture would be caught.
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
    endtask

    // Wait (bounded) until every expected result has been seen, then settle.
    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            chk("timeout_pending", sb.size(), 32'd0);
            sb.delete();
        end
        repeat (3) tick();
    endtask

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        last_q   = 8'd0;
        last_r   = 8'd0;
        last_z   = 1'b0;

        repeat (2) tick();
        chk("rst_busy",      {31'd0, busy},        32'd0);
        chk("rst_done",      {31'd0, done},        32'd0);
        chk("rst_quotient",  {24'd0, quotient},    32'd0);
        chk("rst_remainder", {24'd0, remainder},   32'd0);
        chk("rst_dbz",       {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // 200/7: busy for exactly 8 cycles, then done.
        issue(8'd200, 8'd7, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("busy_iter", {31'd0, busy}, 32'd1);
        end
        drain();

        issue(8'd255, 8'd1,   1'b1); drain();
        issue(8'd5,   8'd255, 1'b1); drain();
        issue(8'd0,   8'd3,   1'b1); drain();
        issue(8'd77,  8'd0,   1'b1); drain();

        // Start while busy is ignored.
        issue(8'd100, 8'd9, 1'b1);
        tick(); tick();
        issue(8'd50, 8'd5, 1'b0);
        drain();

        // Back-to-back: second start lands in the done cycle.
        issue(8'd100, 8'd9, 1'b1);
        repeat (8) tick();
        chk("b2b_done_now", {31'd0, done}, 32'd1);
        issue(8'd50, 8'd5, 1'b1);
        drain();

        // Abort in the 4th ITER cycle: no done, outputs keep prior result.
        issue(8'd100, 8'd9, 1'b0);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy",  {31'd0, busy},        32'd0);
        repeat (12) tick();
        chk("abort_q",     {24'd0, quotient},    {24'd0, last_q});
        chk("abort_r",     {24'd0, remainder},   {24'd0, last_r});
        chk("abort_z",     {31'd0, div_by_zero}, {31'd0, last_z});

        // Reset in the 4th ITER cycle: outputs clear immediately.
        issue(8'd200, 8'd7, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy},        32'd0);
        chk("mid_rst_q",    {24'd0, quotient},    32'd0);
        chk("mid_rst_r",    {24'd0, remainder},   32'd0);
        chk("mid_rst_z",    {31'd0, div_by_zero}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        issue(8'd9, 8'd3, 1'b1);
        drain();

        // Random operations, alternating idle gaps and back-to-back starts.
        for (int n = 0; n < 24; n++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom);
            b = (n % 6 == 5) ? 8'd0 : 8'($urandom_range(255, 1));
            issue(a, b, 1'b1);
            if (b != 8'd0 && n % 2 == 0) repeat (8) tick();
            else drain();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
